// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: bus widths, access-size and FSM
// state encodings, plus small address helpers used by the top level.
package load_store_unit_pkg;

  localparam int unsigned Xlen = 32;       // data/address bus width
  localparam int unsigned BeW  = Xlen / 8; // byte-enable width
  localparam int unsigned TmoW = 16;       // timeout counter width (up to 65535)

  // Access size as carried on req_size; 2'b11 behaves as a word.
  typedef enum logic [1:0] {
    SzByte    = 2'b00,
    SzHalf    = 2'b01,
    SzWord    = 2'b10,
    SzWordAlt = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10,
    StResp = 2'b11
  } state_e;

  // Clear low address bits down to the natural alignment of the access.
  function automatic logic [Xlen-1:0] natural_align(input logic [Xlen-1:0] addr,
                                                    input logic [1:0]      size);
    logic [Xlen-1:0] a;
    a = addr;
    unique case (size_e'(size))
      SzByte:  a = addr;
      SzHalf:  a[0] = 1'b0;
      default: a[1:0] = 2'b00;
    endcase
    return a;
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] offset, input logic [1:0] size);
    logic mis;
    unique case (size_e'(size))
      SzByte:  mis = 1'b0;
      SzHalf:  mis = offset[0];
      default: mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
//   size/offset/is_unsigned : access size, byte offset in word, zero-extend flag
//   wdata -> wdata_rep      : store data replicated across the bus lanes
//   be                      : byte enables for the access
//   rdata -> load_data      : load lane selected by offset, then sign/zero extended
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [1:0]      offset,
  input  logic            is_unsigned,
  input  logic [Xlen-1:0] wdata,
  input  logic [Xlen-1:0] rdata,
  output logic [BeW-1:0]  be,
  output logic [Xlen-1:0] wdata_rep,
  output logic [Xlen-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be        = '1;
    wdata_rep = wdata;
    load_data = rdata;
    unique case (size_e'(size))
      SzByte: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      SzHalf: begin
        be        = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
        load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      default: begin
        be        = '1;
        wdata_rep = wdata;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request from execute, runs it on a
// req/gnt + rvalid memory bus and returns a single writeback pulse.
//   clk, rst (sync, active-high)
//   req_*  : execute-stage request, handshake req_valid/req_ready
//   mem_*  : memory bus (word-aligned address, byte enables)
//   wb_*   : writeback result; bus_err / misalign qualify wb_valid
// Build option: LSU_MISALIGN_EXC_EN turns misaligned half/word accesses into a
// misalign completion with no bus request; otherwise addresses are force-aligned.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  // execute stage
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [Xlen-1:0] req_addr,
  input  logic [Xlen-1:0] req_wdata,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [4:0]      req_rd,
  // memory bus
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [Xlen-1:0] mem_addr,
  output logic            mem_we,
  output logic [BeW-1:0]  mem_be,
  output logic [Xlen-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [Xlen-1:0] mem_rdata,
  // writeback
  output logic            wb_valid,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [Xlen-1:0] wb_data,
  output logic            bus_err,
  output logic            misalign
);

  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [TmoW-1:0] tmo_cnt_q;
  logic            we_q;
  logic            unsigned_q;
  logic [1:0]      size_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;

  logic [Xlen-1:0] eff_addr;
  logic            misaligned_req;
  logic            in_idle;
  logic            tmo_hit;
  logic [1:0]      a_size;
  logic [1:0]      a_off;
  logic [BeW-1:0]  a_be;
  logic [Xlen-1:0] a_wdata;
  logic [Xlen-1:0] a_load;

  assign eff_addr = natural_align(req_addr, req_size);

`ifdef LSU_MISALIGN_EXC_EN
  assign misaligned_req = is_misaligned(req_addr[1:0], req_size);
`else
  assign misaligned_req = 1'b0;
`endif

  assign in_idle   = (state_q == StIdle);
  assign req_ready = in_idle;
  assign tmo_hit   = (tmo_cnt_q == TmoLast);
  assign wb_rd     = rd_q;

  // The aligner serves the incoming request while idle (byte enables and store
  // data are registered at accept) and the latched request afterwards (load extract).
  assign a_size = in_idle ? req_size : size_q;
  assign a_off  = in_idle ? eff_addr[1:0] : off_q;

  lsu_align u_align (
    .size        (a_size),
    .offset      (a_off),
    .is_unsigned (unsigned_q),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .be          (a_be),
    .wdata_rep   (a_wdata),
    .load_data   (a_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tmo_cnt_q  <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      rd_q       <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      wb_valid   <= 1'b0;
      wb_en      <= 1'b0;
      wb_data    <= '0;
      bus_err    <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q       <= req_we;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            off_q      <= eff_addr[1:0];
            rd_q       <= req_rd;
            tmo_cnt_q  <= '0;
            if (misaligned_req) begin
              state_q  <= StResp;
              wb_valid <= 1'b1;
              wb_en    <= 1'b0;
              wb_data  <= '0;
              misalign <= 1'b1;
            end else begin
              state_q   <= StReq;
              mem_req   <= 1'b1;
              mem_addr  <= {eff_addr[Xlen-1:2], 2'b00};
              mem_we    <= req_we;
              mem_be    <= a_be;
              mem_wdata <= a_wdata;
            end
          end
        end

        StReq: begin
          // A grant on the final allowed cycle still times out: the response
          // could not arrive within the budget anyway.
          if (tmo_hit) begin
            state_q  <= StResp;
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_en    <= 1'b0;
            wb_data  <= '0;
            bus_err  <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (mem_gnt) begin
              state_q <= StWait;
              mem_req <= 1'b0;
            end
          end
        end

        StWait: begin
          if (mem_rvalid) begin
            state_q  <= StResp;
            wb_valid <= 1'b1;
            wb_en    <= ~we_q;
            wb_data  <= we_q ? '0 : a_load;
          end else if (tmo_hit) begin
            state_q  <= StResp;
            wb_valid <= 1'b1;
            wb_en    <= 1'b0;
            wb_data  <= '0;
            bus_err  <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        StResp: begin
          state_q  <= StIdle;
          wb_valid <= 1'b0;
          wb_en    <= 1'b0;
          wb_data  <= '0;
          bus_err  <= 1'b0;
          misalign <= 1'b0;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases plus randomized traffic,
// with a memory responder, a bus monitor and a writeback monitor.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [4:0]  req_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, wb_en, bus_err, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_rd       (req_rd),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .bus_err      (bus_err),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        berr;
    logic        mis;
    int          cyc;   // expected cycle of wb_valid, -1 = not checked
  } wb_exp_t;

  typedef struct {
    int          gnt_dly;  // -1 = never grant
    int          rv_dly;
    logic [31:0] rdata;
  } rsp_cfg_t;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];
  rsp_cfg_t rsp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit bus_auto = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from access rules, in plain byte arithmetic.
  function automatic void model(input logic [31:0] addr, input logic [1:0] size,
                                input logic we, input logic uns, input logic [4:0] rd,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output bus_exp_t b, output wb_exp_t w, output bit mis);
    int unsigned nbytes, off;
    logic [31:0] ea, v, lim;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    mis = (addr % nbytes) != 0;
    ea  = addr;
`else
    ea = addr - (addr % nbytes);
`endif
    off     = ea % 4;
    b.addr  = ea - off;
    b.we    = we;
    b.be    = 4'(((32'd1 << nbytes) - 32'd1) << off);
    if (nbytes == 1)      b.wdata = {24'd0, wdata[7:0]} * 32'h0101_0101;
    else if (nbytes == 2) b.wdata = {16'd0, wdata[15:0]} * 32'h0001_0001;
    else                  b.wdata = wdata;
    v = rdata >> (8 * off);
    if (nbytes < 4) begin
      lim = 32'd1 << (8 * nbytes);
      v   = v % lim;
      if (!uns && v >= lim / 2) v = v - lim;
    end
    w.en   = !we && !mis;
    w.rd   = rd;
    w.data = w.en ? v : 32'd0;
    w.berr = 1'b0;
    w.mis  = mis;
    w.cyc  = -1;
  endfunction

  task automatic issue(input logic [31:0] addr, input logic [1:0] size, input logic we,
                       input logic uns, input logic [4:0] rd, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
    bus_exp_t b;
    wb_exp_t  w;
    rsp_cfg_t c;
    bit       mis;
    int       acc;
    int       budget;
    model(addr, size, we, uns, rd, wdata, rdata, b, w, mis);
    @(negedge clk);
    req_addr = addr; req_size = size; req_we = we; req_unsigned = uns;
    req_rd = rd; req_wdata = wdata; req_valid = 1'b1;
    budget = 0;
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      check("accept_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (mis) begin
      w.cyc = acc;
    end else if (gnt_dly < 0) begin
      w.en = 1'b0; w.data = 32'd0; w.berr = 1'b1;
      w.cyc = acc + 8;
    end else begin
      w.cyc = acc + 1 + gnt_dly + rv_dly;
      bus_q.push_back(b);
    end
    if (!mis) begin
      c.gnt_dly = gnt_dly; c.rv_dly = rv_dly; c.rdata = rdata;
      rsp_q.push_back(c);
    end
    wb_q.push_back(w);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (wb_q.size() != 0 || !req_ready); i++) @(negedge clk);
    @(negedge clk);
  endtask

  // Memory responder: one configured response per bus request.
  initial begin
    rsp_cfg_t cfg;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!bus_auto) continue;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!mem_req || rsp_q.size() == 0) continue;
      cfg = rsp_q.pop_front();
      if (cfg.gnt_dly < 0) begin
        for (int i = 0; i < 64 && mem_req; i++) @(negedge clk);
        continue;
      end
      repeat (cfg.gnt_dly) @(negedge clk);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      repeat (cfg.rv_dly - 1) @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = cfg.rdata;
    end
  end

  // Bus monitor: alignment, stability while waiting for grant, granted fields.
  initial begin
    bit          prev_req = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_be;
    logic        p_we;
    bus_exp_t    e;
    forever begin
      @(negedge clk);
      #2;
      if (mem_req) begin
        check("mem_addr_aligned", {30'd0, mem_addr[1:0]}, 32'd0);
        if (prev_req) begin
          check("stable_addr", mem_addr, p_addr);
          check("stable_be", 32'(mem_be), 32'(p_be));
          check("stable_we", 32'(mem_we), 32'(p_we));
          check("stable_wdata", mem_wdata, p_wdata);
        end
        if (mem_gnt) begin
          if (bus_q.size() == 0) begin
            check("unexpected_bus_gnt", 32'(mem_req), 32'd0);
          end else begin
            e = bus_q.pop_front();
            check("mem_addr", mem_addr, e.addr);
            check("mem_be", 32'(mem_be), 32'(e.be));
            check("mem_we", 32'(mem_we), 32'(e.we));
            check("mem_wdata", mem_wdata, e.wdata);
          end
        end
      end
      prev_req = mem_req && !mem_gnt;
      p_addr = mem_addr; p_be = mem_be; p_we = mem_we; p_wdata = mem_wdata;
    end
  end

  // Writeback monitor.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          check("unexpected_wb_valid", 32'(wb_valid), 32'd0);
        end else begin
          e = wb_q.pop_front();
          check("wb_en", 32'(wb_en), 32'(e.en));
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", wb_data, e.data);
          check("bus_err", 32'(bus_err), 32'(e.berr));
          check("misalign", 32'(misalign), 32'(e.mis));
          check("wb_mem_req_low", 32'(mem_req), 32'd0);
          if (e.cyc >= 0) check("wb_latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("flags_idle", {30'd0, bus_err, misalign}, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_rd = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;

    // Word load, minimum latency.
    issue(32'h100, 2'd2, 1'b0, 1'b0, 5'd1, 32'h0, 32'hDEAD_BEEF, 0, 1);
    drain();
    // Signed then unsigned byte load from the top lane.
    issue(32'h103, 2'd0, 1'b0, 1'b0, 5'd2, 32'h0, 32'h80FF_FF00, 0, 1);
    issue(32'h103, 2'd0, 1'b0, 1'b1, 5'd3, 32'h0, 32'h80FF_FF00, 1, 2);
    // Half store with grant delayed three cycles.
    issue(32'h202, 2'd1, 1'b1, 1'b0, 5'd4, 32'h1234_ABCD, 32'h5555_5555, 3, 1);
    // Never granted: bus-error completion.
    issue(32'h400, 2'd2, 1'b0, 1'b0, 5'd5, 32'h0, 32'h0, -1, 1);
    // Misaligned word load.
    issue(32'h101, 2'd2, 1'b0, 1'b0, 5'd6, 32'h0, 32'hCAFE_F00D, 0, 1);
    // Signed half load, upper lane.
    issue(32'h306, 2'd1, 1'b0, 1'b0, 5'd7, 32'h0, 32'h8001_7FFF, 0, 1);
    drain();

    // Reset while waiting for read data; the late rvalid must be ignored.
    bus_auto = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    begin
      bus_exp_t b;
      wb_exp_t  w;
      bit       mis;
      model(32'h300, 2'd2, 1'b0, 1'b0, 5'd9, 32'h0, 32'h0, b, w, mis);
      bus_q.push_back(b);
    end
    @(negedge clk);
    req_addr = 32'h300; req_size = 2'd2; req_we = 1'b0; req_rd = 5'd9; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstwait_req_ready", 32'(req_ready), 32'd1);
    check("rstwait_mem_req", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rstwait_no_wb", 32'(wb_valid), 32'd0);
      check("rstwait_idle", 32'(req_ready), 32'd1);
    end
    bus_auto = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      issue({20'd0, 12'($urandom_range(0, 4095))}, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, $urandom_range(0, 2), $urandom_range(1, 2));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    check("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
